seven_sd_scan_driver: RTL and testbench

Time-multiplexed scan driver for the Mimas A7 four-digit common-anode seven-segment display. It sits directly downstream of the seven-segment controller, taking the controller's packed 32-bit `value` (four 8-bit raw segment patterns) and producing the active-low segment bus and the active-low digit enables that go to the board pins. It scans one digit at a time with an optional anti-ghosting blank gap, and it latches `value` once per frame so a mid-frame update cannot tear the display.

---
 rtl/seven_sd_scan_driver.sv | 97 +++++++++
 tb/tb_seven_sd_scan_driver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seven_sd_scan_driver.sv
// Time-multiplexed scan driver for a four-digit common-anode seven-segment display.
// Latches the packed segment word once per frame and scans digits 0..3, one slot each.
// Optional feature macro: SSD_BLANKING_EN (adds an all-off gap at the end of every slot).
module seven_sd_scan_driver #(
   parameter int unsigned DIGIT_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] value,
   output logic [7:0]  displayOut,
   output logic [3:0]  enableOut,
   output logic        frameStart
);

   localparam int unsigned CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

`ifdef SSD_BLANKING_EN
   localparam bit BLANK_EN = 1'b1;
`else
   localparam bit BLANK_EN = 1'b0;
`endif

   // Slot position at which the digit is switched off; only meaningful with blanking.
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(DIGIT_CYCLES - BLANK_CYCLES);

   // Reject parameter sets that would break slot sequencing.
   if (DIGIT_CYCLES < 2) begin : g_bad_digit_cycles
      $fatal(1, "seven_sd_scan_driver: DIGIT_CYCLES must be >= 2");
   end

`ifdef SSD_BLANKING_EN
   if ((BLANK_CYCLES < 1) || (BLANK_CYCLES >= DIGIT_CYCLES)) begin : g_bad_blank_cycles
      $fatal(1, "seven_sd_scan_driver: BLANK_CYCLES must be in [1, DIGIT_CYCLES-1]");
   end
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [31:0]      shadow_q, shadow_d;
   logic [7:0]       display_q, display_d;
   logic [3:0]       enable_q, enable_d;
   logic             frame_start_q, frame_start_d;
   logic             cnt_wrap_c;

   // Next-state: slot counter, digit index, frame latch and registered pin values.
   always_comb begin
      cnt_wrap_c    = (cnt_q == LAST_CNT);
      cnt_d         = cnt_wrap_c ? '0 : cnt_q + CNT_W'(1);
      idx_d         = cnt_wrap_c ? idx_q + 2'd1 : idx_q;
      shadow_d      = shadow_q;
      display_d     = display_q;
      enable_d      = enable_q;
      frame_start_d = 1'b0;

      if (cnt_q == '0) begin
         if (idx_q == 2'd0) begin
            // Digit 0 comes straight from value so it is lit one edge after capture.
            shadow_d      = value;
            display_d     = ~value[7:0];
            enable_d      = 4'b1110;
            frame_start_d = 1'b1;
         end else begin
            display_d = ~shadow_q[8*idx_q +: 8];
            enable_d  = ~(4'b0001 << idx_q);
         end
      end else if (BLANK_EN && (cnt_q == BLANK_CNT)) begin
         display_d = 8'hFF;
         enable_d  = 4'hF;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q         <= '0;
         idx_q         <= 2'd0;
         shadow_q      <= 32'd0;
         display_q     <= 8'hFF;
         enable_q      <= 4'hF;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         display_q     <= display_d;
         enable_q      <= enable_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign displayOut = display_q;
   assign enableOut  = enable_q;
   assign frameStart = frame_start_q;

endmodule

// File: tb/tb_seven_sd_scan_driver.sv
// Directed self-checking bench for seven_sd_scan_driver (DIGIT_CYCLES=8, BLANK_CYCLES=2).
// Expectations follow the SSD_BLANKING_EN setting the bench is compiled with.
module tb_seven_sd_scan_driver;

   localparam int unsigned DC = 8;
   localparam int unsigned BC = 2;
   localparam int unsigned FRAME = 4 * DC;

`ifdef SSD_BLANKING_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] value;
   logic [7:0]  display_out;
   logic [3:0]  enable_out;
   logic        frame_start;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   seven_sd_scan_driver #(
      .DIGIT_CYCLES(DC),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .value     (value),
      .displayOut(display_out),
      .enableOut (enable_out),
      .frameStart(frame_start)
   );

   // Expected anodes at frame position p (p=0 is the observation right after a frame-start edge).
   function automatic logic [3:0] exp_en(input int p);
      int k;
      int off;
      k   = p / int'(DC);
      off = p % int'(DC);
      if (BLANK && (off >= int'(DC - BC))) return 4'hF;
      return ~(4'b0001 << k);
   endfunction

   // Expected cathodes at frame position p for the word captured at that frame start.
   function automatic logic [7:0] exp_disp(input int p, input logic [31:0] fv);
      int k;
      int off;
      k   = p / int'(DC);
      off = p % int'(DC);
      if (BLANK && (off >= int'(DC - BC))) return 8'hFF;
      return ~fv[8*k +: 8];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      value = 32'hDEADBEEF;
      tick();
      tick();
      total++;
      if (display_out !== 8'hFF) $display("FAIL reset_disp got %h want ff", display_out);
      else passed++;
      total++;
      if (enable_out !== 4'hF) $display("FAIL reset_en got %b want 1111", enable_out);
      else passed++;
      total++;
      if (frame_start !== 1'b0) $display("FAIL reset_fs got %b want 0", frame_start);
      else passed++;
   endtask

   // First frame after release with the test-plan word, including hand-decoded checkpoints.
   task automatic test_sequence;
      value = 32'h4F5B0630;
      rst   = 1'b0;
      for (int p = 0; p < int'(FRAME); p++) begin
         tick();
         total++;
         if (enable_out !== exp_en(p) || display_out !== exp_disp(p, 32'h4F5B0630) ||
             frame_start !== (p == 0))
            $display("FAIL seq p=%0d got en=%b disp=%h fs=%b want en=%b disp=%h fs=%b", p,
                     enable_out, display_out, frame_start, exp_en(p),
                     exp_disp(p, 32'h4F5B0630), p == 0);
         else passed++;
         if (p == 0) begin
            total++;
            if (enable_out !== 4'b1110 || display_out !== 8'hCF || frame_start !== 1'b1)
               $display("FAIL seq_first got en=%b disp=%h fs=%b want 1110/cf/1",
                        enable_out, display_out, frame_start);
            else passed++;
         end
         if (p == 8) begin
            total++;
            if (enable_out !== 4'b1101 || display_out !== 8'hF9)
               $display("FAIL seq_d1 got en=%b disp=%h want 1101/f9", enable_out, display_out);
            else passed++;
         end
         if (p == 16) begin
            total++;
            if (enable_out !== 4'b1011 || display_out !== 8'hA4)
               $display("FAIL seq_d2 got en=%b disp=%h want 1011/a4", enable_out, display_out);
            else passed++;
         end
         if (p == 24) begin
            total++;
            if (enable_out !== 4'b0111 || display_out !== 8'hB0)
               $display("FAIL seq_d3 got en=%b disp=%h want 0111/b0", enable_out, display_out);
            else passed++;
         end
      end
   endtask

   // value changes in slot 2 must not tear the current frame; it appears one frame later.
   task automatic test_no_tear;
      for (int p = 0; p < int'(FRAME); p++) begin
         tick();
         total++;
         if (enable_out !== exp_en(p) || display_out !== exp_disp(p, 32'h4F5B0630))
            $display("FAIL tear_old p=%0d got en=%b disp=%h want en=%b disp=%h", p,
                     enable_out, display_out, exp_en(p), exp_disp(p, 32'h4F5B0630));
         else passed++;
         if (p == 17) value = 32'hFFFFFFFF;
      end
      for (int p = 0; p < int'(FRAME); p++) begin
         tick();
         total++;
         if (enable_out !== exp_en(p) || display_out !== exp_disp(p, 32'hFFFFFFFF) ||
             frame_start !== (p == 0))
            $display("FAIL tear_new p=%0d got en=%b disp=%h fs=%b want en=%b disp=%h", p,
                     enable_out, display_out, frame_start, exp_en(p),
                     exp_disp(p, 32'hFFFFFFFF));
         else passed++;
      end
   endtask

   // One-cycle reset at cnt=5, idx=2, then restart at digit 0 with a new word.
   task automatic test_mid_reset;
      for (int p = 0; p < 21; p++) tick();
      rst = 1'b1;
      tick();
      total++;
      if (enable_out !== 4'hF || display_out !== 8'hFF || frame_start !== 1'b0)
         $display("FAIL midrst_hold got en=%b disp=%h fs=%b want 1111/ff/0",
                  enable_out, display_out, frame_start);
      else passed++;
      rst   = 1'b0;
      value = 32'h12345678;
      tick();
      total++;
      if (enable_out !== 4'b1110 || display_out !== 8'h87 || frame_start !== 1'b1)
         $display("FAIL midrst_restart got en=%b disp=%h fs=%b want 1110/87/1",
                  enable_out, display_out, frame_start);
      else passed++;
      for (int p = 1; p < int'(FRAME); p++) begin
         tick();
         total++;
         if (enable_out !== exp_en(p) || display_out !== exp_disp(p, 32'h12345678) ||
             frame_start !== 1'b0)
            $display("FAIL midrst p=%0d got en=%b disp=%h fs=%b want en=%b disp=%h", p,
                     enable_out, display_out, frame_start, exp_en(p),
                     exp_disp(p, 32'h12345678));
         else passed++;
      end
   endtask

   // Five frames of value=0: enables keep scanning, segments stay dark, period is 32.
   task automatic test_period_zero;
      int last_pulse;
      logic [3:0] prev_en;
      last_pulse = -1;
      prev_en    = enable_out;
      value      = 32'h0;
      for (int i = 0; i < 5 * int'(FRAME); i++) begin
         int p;
         tick();
         p = i % int'(FRAME);
         total++;
         if (enable_out !== exp_en(p) || display_out !== 8'hFF || frame_start !== (p == 0))
            $display("FAIL zero i=%0d got en=%b disp=%h fs=%b want en=%b disp=ff", i,
                     enable_out, display_out, frame_start, exp_en(p));
         else passed++;
         total++;
         if ($countones(~enable_out) > 1)
            $display("FAIL twohot i=%0d got en=%b want at most one low", i, enable_out);
         else passed++;
         total++;
         if (BLANK && prev_en !== 4'hF && enable_out !== 4'hF && enable_out !== prev_en)
            $display("FAIL direct_switch i=%0d got %b after %b want 1111 gap", i,
                     enable_out, prev_en);
         else passed++;
         if (frame_start === 1'b1) begin
            if (last_pulse >= 0) begin
               total++;
               if (i - last_pulse != int'(FRAME))
                  $display("FAIL fs_period got %0d want %0d", i - last_pulse, FRAME);
               else passed++;
            end
            last_pulse = i;
         end
         prev_en = enable_out;
      end
      total++;
      if (last_pulse != 4 * int'(FRAME))
         $display("FAIL fs_last got %0d want %0d", last_pulse, 4 * FRAME);
      else passed++;
   endtask

   initial begin
      rst   = 1'b1;
      value = 32'h0;
      test_reset();
      test_sequence();
      test_no_tear();
      test_mid_reset();
      test_period_zero();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
